// File: rtl/filter_pkg.sv
// Shared types and constants for the multi-channel filtration controller.
// Channel state encoding is visible on state_out for debug.
package filter_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FILLING   = 3'd1,
    RETURNING = 3'd2,
    DRAINING  = 3'd3,
    FAULT     = 3'd4
  } state_t;

  localparam int DUTY_ON_DEF = 230;

  function automatic logic is_pumping(state_t s);
    return (s == FILLING) ||
           (s == RETURNING) ||
           (s == DRAINING);
  endfunction

endpackage

// File: rtl/filter_channel_fsm.sv
// One filter channel: float synchronisers, pump timer, loop
// counter, fill/return/drain FSM and pump duty decode.
module filter_channel_fsm
  import filter_pkg::*;
#(
  parameter int STATUS_W    = 4,
  parameter int DUTY_W      = 8,
  parameter int DUTY_ON     = DUTY_ON_DEF,
  parameter int TIMEOUT_CYC = 50_000_000,
  parameter int MAX_LOOPS   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [STATUS_W-1:0] status,
  input  logic                float_full,
  input  logic                float_empty,
  input  logic                fault_clear,
  output logic [DUTY_W-1:0]   pump_a_duty,
  output logic [DUTY_W-1:0]   pump_b_duty,
  output logic                fault,
  output logic [2:0]          state_o
);

  localparam int TW = (TIMEOUT_CYC > 1) ?
                      $clog2(TIMEOUT_CYC + 1) : 1;
  localparam int LW = (MAX_LOOPS > 1) ?
                      $clog2(MAX_LOOPS) : 1;

  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [LW-1:0] L_LAST = LW'(MAX_LOOPS - 1);
  localparam logic [DUTY_W-1:0] D_ON = DUTY_W'(DUTY_ON);

  logic full_s1, full_s2;
  logic empty_s1, empty_s2;

  state_t        state, nxt;
  logic [TW-1:0] timer;
  logic [LW-1:0] loops;
  logic          loop_clr, loop_inc;
  logic          pumping;

  assign pumping = is_pumping(state);

  // two-flop synchronisers for the asynchronous float switches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_s1  <= 1'b0;
      full_s2  <= 1'b0;
      empty_s1 <= 1'b0;
      empty_s2 <= 1'b0;
    end else begin
      full_s1  <= float_full;
      full_s2  <= full_s1;
      empty_s1 <= float_empty;
      empty_s2 <= empty_s1;
    end
  end

  // next-state selection: conflict, then timeout, then normal flow
  always_comb begin
    nxt      = state;
    loop_clr = 1'b0;
    loop_inc = 1'b0;
    if (state != FAULT && full_s2 && empty_s2) begin
      nxt = FAULT;
    end else if (pumping && timer == T_LAST) begin
      nxt = FAULT;
    end else begin
      unique case (state)
        IDLE: begin
          if (|status) begin
            nxt      = FILLING;
            loop_clr = 1'b1;
          end
        end
        FILLING: begin
          if (full_s2) nxt = RETURNING;
        end
        RETURNING: begin
          if (status == '0) begin
            nxt = DRAINING;
          end else if (empty_s2) begin
            if (loops == L_LAST) begin
              nxt = DRAINING;
            end else begin
              nxt      = FILLING;
              loop_inc = 1'b1;
            end
          end
        end
        DRAINING: begin
          if (empty_s2) nxt = IDLE;
        end
        FAULT: begin
          if (fault_clear) begin
            nxt      = IDLE;
            loop_clr = 1'b1;
          end
        end
        default: nxt = IDLE;
      endcase
    end
  end

  // state, saturating pump timer and recirculation counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      timer <= '0;
      loops <= '0;
    end else begin
      state <= nxt;
      if (nxt != state) begin
        timer <= '0;
      end else if (pumping && timer != '1) begin
        timer <= timer + 1'b1;
      end
      if (loop_clr) begin
        loops <= '0;
      end else if (loop_inc) begin
        loops <= loops + 1'b1;
      end
    end
  end

  // pump duties follow the registered state directly
  always_comb begin
    pump_a_duty = '0;
    pump_b_duty = '0;
    unique case (1'b1)
      (state == FILLING): begin
        pump_a_duty = D_ON;
      end
      (state == RETURNING),
      (state == DRAINING): begin
        pump_b_duty = D_ON;
      end
      default: begin
        pump_a_duty = '0;
        pump_b_duty = '0;
      end
    endcase
  end

  assign fault   = (state == FAULT);
  assign state_o = state;

endmodule

// File: rtl/filter_ctrl_multi.sv
// Multi-channel filtration controller: status capture with
// channel range check, one independent FSM per channel.
module filter_ctrl_multi
  import filter_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int STATUS_W    = 4,
  parameter int DUTY_W      = 8,
  parameter int DUTY_ON     = DUTY_ON_DEF,
  parameter int TIMEOUT_CYC = 50_000_000,
  parameter int MAX_LOOPS   = 4,
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     status_valid_in,
  input  logic [CHW-1:0]           status_ch_in,
  input  logic [STATUS_W-1:0]      status_data_in,
  output logic                     status_err_out,
  input  logic [NUM_CH-1:0]        float_full_in,
  input  logic [NUM_CH-1:0]        float_empty_in,
  input  logic [NUM_CH-1:0]        fault_clear_in,
  output logic [NUM_CH*DUTY_W-1:0] pump_a_duty_out,
  output logic [NUM_CH*DUTY_W-1:0] pump_b_duty_out,
  output logic [NUM_CH-1:0]        fault_out,
  output logic [NUM_CH*3-1:0]      state_out
);

  logic [STATUS_W-1:0] status_reg [NUM_CH];
  logic                ch_ok;

  assign ch_ok = (32'(status_ch_in) < 32'(NUM_CH));

  // latch status words; flag writes to nonexistent channels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_err_out <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        status_reg[c] <= '0;
      end
    end else begin
      status_err_out <= status_valid_in && !ch_ok;
      for (int c = 0; c < NUM_CH; c++) begin
        if (status_valid_in && ch_ok &&
            32'(status_ch_in) == c) begin
          status_reg[c] <= status_data_in;
        end
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    filter_channel_fsm #(
      .STATUS_W    (STATUS_W),
      .DUTY_W      (DUTY_W),
      .DUTY_ON     (DUTY_ON),
      .TIMEOUT_CYC (TIMEOUT_CYC),
      .MAX_LOOPS   (MAX_LOOPS)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .status      (status_reg[c]),
      .float_full  (float_full_in[c]),
      .float_empty (float_empty_in[c]),
      .fault_clear (fault_clear_in[c]),
      .pump_a_duty (pump_a_duty_out[c*DUTY_W +: DUTY_W]),
      .pump_b_duty (pump_b_duty_out[c*DUTY_W +: DUTY_W]),
      .fault       (fault_out[c]),
      .state_o     (state_out[c*3 +: 3])
    );
  end

endmodule

// File: doc/filter_ctrl_multi.md
# filter_ctrl_multi

Multi-channel, parametrised successor to the single-tank filtration controller. It runs one independent fill/return/drain state machine per filter channel. Each FSM is driven by a per-channel strategic status word and per-channel float sensors. New behaviour: pump-timeout and float-conflict fault detection, a bounded recirculation loop count, and per-channel fault clear. It sits between the Pico status handshake receiver (upstream) and the per-pump PWM generators (downstream, which consume the duty outputs).

## Interface
- NUM_CH, 2, number of filter channels (1..8)
- STATUS_W, 4, width of the strategic status word per channel
- DUTY_W, 8, pump duty width
- DUTY_ON, 230, duty applied to an active pump (~90 % at 8 bits)
- TIMEOUT_CYC, 50_000_000, maximum cycles in any pumping state before fault
- MAX_LOOPS, 4, maximum RETURNING->FILLING recirculations before a forced drain
- clk  in  1  system clock; single clock domain
- rst_n  in  1  asynchronous, active-low reset
- status_valid_in  in  1  one-cycle pulse: status_ch_in/status_data_in are valid
- status_ch_in  in  $clog2(NUM_CH) (min 1)  target channel
- status_data_in  in  STATUS_W  new status word
- status_err_out  out  1  one-cycle pulse: status_ch_in >= NUM_CH was received
- float_full_in  in  NUM_CH  asynchronous full float, per channel
- float_empty_in  in  NUM_CH  asynchronous empty float, per channel
- fault_clear_in  in  NUM_CH  per-channel fault acknowledge pulse
- pump_a_duty_out  out  NUM_CH*DUTY_W  fill-pump duty; channel c at [c*DUTY_W +: DUTY_W]
- pump_b_duty_out  out  NUM_CH*DUTY_W  return/drain-pump duty; same packing
- fault_out  out  NUM_CH  channel is in FAULT
- state_out  out  NUM_CH*3  encoded channel state, for debug

## Operation
- Reset: all states IDLE; status regs, loop counters and timers 0; all duties 0; fault_out 0; status_err_out 0.
- Status capture: on status_valid_in with a valid channel, status_reg[ch] <= status_data_in. An invalid channel leaves every status_reg unchanged and pulses status_err_out.
- Float inputs: each passes through a 2-flop synchroniser per channel.
- Per-channel states: IDLE, FILLING, RETURNING, DRAINING, FAULT.
- Transition priority, evaluated each cycle, first match wins:
  1. Synced full && empty, in any state except FAULT -> FAULT.
  2. Timer == TIMEOUT_CYC-1, in FILLING/RETURNING/DRAINING -> FAULT.
  3. Normal transitions:
     - IDLE -> FILLING if |status_reg; the loop counter clears to 0.
     - FILLING -> RETURNING on synced full.
     - RETURNING -> DRAINING if status_reg == 0.
     - RETURNING -> DRAINING on synced empty when loops == MAX_LOOPS-1.
     - RETURNING -> FILLING on synced empty otherwise; loops increments.
     - DRAINING -> IDLE on synced empty.
     - FAULT -> IDLE on fault_clear_in[ch]; the loop counter clears.
- Timer: clears on every state change and increments while in a pumping state. It saturates and never wraps.
- Duties: combinational decode of the registered state.
  - FILLING: a = DUTY_ON, b = 0.
  - RETURNING/DRAINING: a = 0, b = DUTY_ON.
  - IDLE/FAULT: both 0.
- fault_out[ch] = (state == FAULT). fault_clear_in is ignored outside FAULT.
- status_reg keeps updating in every state, including FAULT.

## Timing
- Status write on edge N is visible to the FSM at edge N+1. The resulting state change appears at edge N+1, and the duty output changes in the same cycle as the state change.
- A float edge reaches the synchronised value after 2 edges; the state change happens on the 3rd edge.
- Timeout: the FAULT entry occurs exactly TIMEOUT_CYC edges after entering the pumping state.
- Channels are fully independent; simultaneous events on different channels are all honoured in the same cycle.
- Asynchronous reset mid-operation forces all outputs to their reset values immediately. No state is retained.

## Structure
- Shared package filter_pkg holds:
  - state_t (3-bit enum: IDLE=0, FILLING=1, RETURNING=2, DRAINING=3, FAULT=4)
  - the default DUTY_ON constant
- Sub-module filter_channel_fsm: one channel containing the synchroniser, timer, loop counter, FSM and duty decode. It is instantiated NUM_CH times in a generate loop. The top level keeps status capture and the invalid-channel check.

## Test plan
Bench parameters: NUM_CH=2, TIMEOUT_CYC=16, MAX_LOOPS=2.
- **Normal cycle:** reset, write ch0=4'b0010, pulse full, then write ch0=0 → ch0 steps IDLE→FILLING→RETURNING→DRAINING (a=230 while FILLING, b=230 while RETURNING). Pulse empty → IDLE. ch1 stays IDLE with duties 0.
- **Loop bound:** ch1=4'b0001 held nonzero; cycle full/empty repeatedly → second empty in RETURNING goes to DRAINING, not FILLING; next empty → IDLE.
- **Timeout:** ch0=4'b1000, float never full → fault_out[0]=1 exactly 16 cycles after FILLING entry; duties 0. Pulse fault_clear_in[0] → IDLE, then FILLING next cycle since status is still nonzero.
- **Float conflict:** in RETURNING, assert full and empty together on ch1 → FAULT 3 cycles later; ch0 unaffected.
- **Invalid channel:** status_ch_in=1 with NUM_CH=2 is valid. Rerun with NUM_CH=3 and status_ch_in=3 → status_err_out pulses 1 cycle and no status_reg changes.
- **Reset mid-fill:** deassert rst_n while ch0 is FILLING → all duties 0, state_out=0 and fault_out=0 with no clock edge required.
